fire_game_ctrl: RTL

//   Game-logic stage directly upstream of the VGA display controller. Runs the

---
 rtl/fire_game_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fire_game_ctrl.sv
// Game-logic stage for the fire game: INIT/PLAY/FINISH FSM, LFSR-driven fire and CT box spawning, aging, scoring and lives.
// Optional feature: define MISS_PENALTY_EN to charge one life per hit on an empty cell.
module fire_game_ctrl #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned SPAWN_PERIOD = 2,
  parameter int unsigned FIRE_TIMEOUT = 3,
  parameter int unsigned BOX_TICKS    = 2,
  parameter int unsigned MAX_LIFE     = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] hit,
  output logic [1:0] game_state,
  output logic [7:0] score,
  output logic [8:0] fire_state,
  output logic [8:0] box,
  output logic [1:0] life
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_PERIOD - 1);
  localparam logic [1:0]    FIRE_END   = 2'(FIRE_TIMEOUT);
  localparam logic [1:0]    BOX_END    = 2'(BOX_TICKS);
  localparam logic [1:0]    LIFE_INIT  = 2'(MAX_LIFE);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_PLAY   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   spawn_cnt;
  logic [15:0]     lfsr, lfsr_n;
  logic [8:0][1:0] fire_age, box_age, fire_age_n, box_age_n;
  logic            tick, spawn;
  logic [3:0]      cand;
  logic [8:0]      occupied, hit_fire, hit_box, miss;
  logic [8:0]      fire_exp, box_exp, fire_keep, box_keep, spawn_onehot;
  logic [8:0]      fire_n, box_n;
  logic [5:0]      pts;
  logic [4:0]      loss;
  logic [8:0]      score_sum;
  logic [7:0]      score_n;
  logic [1:0]      life_n;

  assign game_state = state;

  always_comb begin
    lfsr_n   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    tick     = (state == S_PLAY) && (tick_cnt == TICK_LAST);
    spawn    = tick && (spawn_cnt == SPAWN_LAST);
    occupied = fire_state | box;
    hit_fire = hit & fire_state;
    hit_box  = hit & box;
`ifdef MISS_PENALTY_EN
    miss     = hit & ~occupied;
`else
    miss     = '0;
`endif

    // A hit on a cell suppresses its expiry on the same tick
    fire_exp   = '0;
    box_exp    = '0;
    fire_age_n = fire_age;
    box_age_n  = box_age;
    for (int unsigned i = 0; i < 9; i++) begin
      if (tick && fire_state[i] && !hit[i]) begin
        if (fire_age[i] + 2'd1 == FIRE_END) fire_exp[i] = 1'b1;
        else fire_age_n[i] = fire_age[i] + 2'd1;
      end
      if (tick && box[i] && !hit[i]) begin
        if (box_age[i] + 2'd1 == BOX_END) box_exp[i] = 1'b1;
        else box_age_n[i] = box_age[i] + 2'd1;
      end
    end
    fire_keep = fire_state & ~hit & ~fire_exp;
    box_keep  = box & ~hit & ~box_exp;

    // Spawn decisions look only at the registered (pre-hit, pre-expiry) occupancy
    cand         = (lfsr[3:0] >= 4'd9) ? lfsr[3:0] - 4'd9 : lfsr[3:0];
    spawn_onehot = '0;
    if (spawn && !occupied[cand]) spawn_onehot[cand] = 1'b1;
    if (lfsr[7:4] == 4'd0 && box == '0) begin
      box_n  = box_keep | spawn_onehot;
      fire_n = fire_keep;
    end else begin
      fire_n = fire_keep | spawn_onehot;
      box_n  = box_keep;
    end
    for (int unsigned i = 0; i < 9; i++) begin
      if (spawn_onehot[i]) begin
        fire_age_n[i] = '0;
        box_age_n[i]  = '0;
      end
    end

    pts  = '0;
    loss = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      pts  = pts + 6'(hit_fire[i]) + (hit_box[i] ? 6'd5 : 6'd0);
      loss = loss + 5'(fire_exp[i]) + 5'(miss[i]);
    end
    score_sum = {1'b0, score} + {3'b000, pts};
    score_n   = score_sum[8] ? 8'hFF : score_sum[7:0];
    life_n    = ({3'b000, life} <= loss) ? 2'd0 : life - loss[1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INIT;
      score      <= '0;
      fire_state <= '0;
      box        <= '0;
      life       <= LIFE_INIT;
      fire_age   <= '0;
      box_age    <= '0;
      tick_cnt   <= '0;
      spawn_cnt  <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_n;
      unique case (state)
        S_INIT: begin
          if (start) begin
            state     <= S_PLAY;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
          end
        end
        S_PLAY: begin
          if (life == '0) begin
            state      <= S_FINISH;
            fire_state <= '0;
            box        <= '0;
          end else begin
            tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) spawn_cnt <= spawn ? '0 : spawn_cnt + SW'(1);
            score      <= score_n;
            life       <= life_n;
            fire_state <= fire_n;
            box        <= box_n;
            fire_age   <= fire_age_n;
            box_age    <= box_age_n;
          end
        end
        S_FINISH: begin
          if (start) begin
            state      <= S_INIT;
            score      <= '0;
            life       <= LIFE_INIT;
            fire_state <= '0;
            box        <= '0;
            fire_age   <= '0;
            box_age    <= '0;
            tick_cnt   <= '0;
            spawn_cnt  <= '0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
